axa_undo_unwinder: RTL and testbench
====================================

// Module: axa_undo_unwinder
// PURPOSE
//  Read/pop end of the AXA undo stack. The ALU pushes pre-write dest values; this block drains them on jerr/fail.
//  On a trigger it pops one entry at a time and writes each saved value back to the register file.
//  It stops at the most recent land marker and reloads the PC from that marker.
//  While unwinding it freezes the front of the pipeline.
// PARAMETERS
//  WORD_W      16  data/PC width
//  REG_AW      4   register address width (16 regs)
//  MAX_UNWIND  16  max register entries popped before a land marker; exceeding this is an error
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-low reset
//  start         in   1       1-cycle trigger from reg-write stage (jerr taken / fail)
//  busy          out  1       high from cycle after accepted start until return to IDLE
//  stall         out  1       = busy; freezes load/decode and reg-read stages
//  pop_req       out  1       request next stack entry; held until pop_ack or underflow
//  pop_ack       in   1       entry presented this cycle on pop_data/pop_reg/pop_tag
//  pop_data      in   WORD_W  saved register value, or land PC
//  pop_reg       in   REG_AW  register the value belongs to (ignored for land)
//  pop_tag       in   2       00 reg entry, 01 land marker, 1x reserved
//  stack_empty   in   1       undo stack has no entries
//  rf_we         out  1       register-file write strobe, 1 cycle per restored entry
//  rf_waddr      out  REG_AW  restore address
//  rf_wdata      out  WORD_W  restore value
//  pc_load       out  1       1-cycle PC reload strobe
//  pc_value      out  WORD_W  PC to resume at (land PC)
//  restored      out  5       reg entries restored in current/last unwind
//  err           out  1       sticky fault; cleared by next accepted start
// BEHAVIOUR
//  Reset (async, reset==0): FSM=IDLE; all outputs 0; no partial writes are reversed. A mid-unwind reset abandons the unwind.
//  FSM states: IDLE, POP, WRITE, LOAD, FAULT.
//  IDLE: start=1 -> POP next edge; clear restored and err. busy=1 from that edge. start while busy is ignored.
//  POP: pop_req=1 (registered, asserted the cycle POP is entered).
//   - pop_ack=1 takes priority over stack_empty. Capture data/reg/tag on that edge and drop pop_req the next cycle.
//   - tag 00 -> WRITE. tag 01 -> LOAD. tag 1x -> FAULT.
//   - no ack and stack_empty=1 -> FAULT (underflow: no land marker).
//  WRITE: rf_we=1 exactly one cycle with captured reg/value; restored+1 (saturates at 31).
//   - If restored reaches MAX_UNWIND -> FAULT; else -> POP.
//   - Minimum 2 cycles per restored entry: POP(ack) + WRITE.
//  LOAD: pc_load=1 and pc_value=captured data for one cycle -> IDLE. The land entry is consumed.
//  FAULT: err=1 (sticky), pop_req=0, no pc_load -> IDLE. Processor halts on err (sys path).
//  Pop order is LIFO: newest first, so the last write of a register restores its oldest saved value.
//  Outputs are registered. rf_waddr/rf_wdata/pc_value hold their last value when their strobe is low.
//  Latency: start -> first pop_req is 1 cycle. For N reg entries plus land with 0-wait acks: start -> pc_load is 2N+2 cycles.
// STRUCTURE
//  Shared package axa_pkg: WORD width, undo tag constants (TAG_REG=2'b00, TAG_LAND=2'b01), OPjerr/fail opcodes, unwind FSM state encodings.
//  Single module with no sub-module. The stack storage itself stays in the existing undo stack block.
// TESTING
//  1 Stack [land PC=0x0040, r3=0x1234, r5=0xBEEF (top)], 0-wait acks, pulse start.
//    -> rf writes r5=0xBEEF then r3=0x1234; pc_load with 0x0040 at cycle 6; restored=2; err=0.
//  2 Stack [land PC=0x0010] only.
//    -> no rf_we; pc_load with 0x0010 two cycles after start; busy 2 cycles.
//  3 Stack [r1=0x0001] with no land, then stack_empty.
//    -> one write r1=1; err=1; pc_load never asserts; busy drops.
//  4 pop_ack delayed 3 cycles per entry.
//    -> pop_req held steady with no duplicate pops; write order and values as in 1.
//  5 17 reg entries, no land (MAX_UNWIND=16).
//    -> 16 writes; err=1; 17th entry not popped.
//  6 reset low during WRITE of test 1, then start again.
//    -> all outputs 0 immediately; after release, IDLE; second start unwinds remaining entries.
//    Also: start pulsed while busy -> ignored, restored count unaffected.

Source files
------------

// File: rtl/axa_pkg.sv
// Shared AXA definitions: data widths, undo-stack tag encodings, opcodes that
// trigger an unwind, and the unwinder state encoding.
package axa_pkg;

   localparam int AXA_WORD_W     = 16;
   localparam int AXA_REG_AW     = 4;
   localparam int AXA_MAX_UNWIND = 16;
   localparam int AXA_CNT_W      = 5;

   localparam logic [1:0] TAG_REG  = 2'b00;
   localparam logic [1:0] TAG_LAND = 2'b01;

   localparam logic [5:0] OP_JERR = 6'h2A;
   localparam logic [5:0] OP_FAIL = 6'h2B;

   typedef enum logic [2:0] {
      UW_IDLE,
      UW_POP,
      UW_WRITE,
      UW_LOAD,
      UW_FAULT
   } unwind_state_t;

   function automatic logic [AXA_CNT_W-1:0] satInc(input logic [AXA_CNT_W-1:0] v);
      return (v == {AXA_CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/axa_undo_unwinder.sv
// Drains the AXA undo stack after jerr/fail: restores saved register values
// newest-first until a land marker, then reloads the PC from that marker.
module axa_undo_unwinder
   import axa_pkg::*;
#(
   parameter int WORD_W     = AXA_WORD_W,
   parameter int REG_AW     = AXA_REG_AW,
   parameter int MAX_UNWIND = AXA_MAX_UNWIND
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              stall,
   output logic              pop_req,
   input  logic              pop_ack,
   input  logic [WORD_W-1:0] pop_data,
   input  logic [REG_AW-1:0] pop_reg,
   input  logic [1:0]        pop_tag,
   input  logic              stack_empty,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [WORD_W-1:0] rf_wdata,
   output logic              pc_load,
   output logic [WORD_W-1:0] pc_value,
   output logic [4:0]        restored,
   output logic              err
);

   localparam logic [4:0] MAX_CNT = 5'(MAX_UNWIND);

   unwind_state_t     r_state;
   logic              r_busy;
   logic              r_popReq;
   logic              r_rfWe;
   logic [REG_AW-1:0] r_rfWaddr;
   logic [WORD_W-1:0] r_rfWdata;
   logic              r_pcLoad;
   logic [WORD_W-1:0] r_pcValue;
   logic [4:0]        r_restored;
   logic              r_err;

   // Every output is set on the edge that enters the state it belongs to, so
   // strobes are visible exactly during the WRITE/LOAD cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= UW_IDLE;
         r_busy     <= 1'b0;
         r_popReq   <= 1'b0;
         r_rfWe     <= 1'b0;
         r_rfWaddr  <= '0;
         r_rfWdata  <= '0;
         r_pcLoad   <= 1'b0;
         r_pcValue  <= '0;
         r_restored <= '0;
         r_err      <= 1'b0;
      end else begin
         r_rfWe   <= 1'b0;
         r_pcLoad <= 1'b0;
         case (r_state)
            UW_IDLE: begin
               if (start) begin
                  r_state    <= UW_POP;
                  r_busy     <= 1'b1;
                  r_popReq   <= 1'b1;
                  r_restored <= '0;
                  r_err      <= 1'b0;
               end
            end
            UW_POP: begin
               // An ack wins over stack_empty: the entry on the bus is still valid.
               if (pop_ack) begin
                  r_popReq <= 1'b0;
                  case (pop_tag)
                     TAG_REG: begin
                        r_state    <= UW_WRITE;
                        r_rfWe     <= 1'b1;
                        r_rfWaddr  <= pop_reg;
                        r_rfWdata  <= pop_data;
                        r_restored <= satInc(r_restored);
                     end
                     TAG_LAND: begin
                        r_state   <= UW_LOAD;
                        r_pcLoad  <= 1'b1;
                        r_pcValue <= pop_data;
                     end
                     default: begin
                        r_state <= UW_FAULT;
                        r_err   <= 1'b1;
                     end
                  endcase
               end else if (stack_empty) begin
                  r_state  <= UW_FAULT;
                  r_popReq <= 1'b0;
                  r_err    <= 1'b1;
               end
            end
            UW_WRITE: begin
               if (r_restored >= MAX_CNT) begin
                  r_state <= UW_FAULT;
                  r_err   <= 1'b1;
               end else begin
                  r_state  <= UW_POP;
                  r_popReq <= 1'b1;
               end
            end
            UW_LOAD, UW_FAULT: begin
               r_state <= UW_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= UW_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign stall    = r_busy;
   assign pop_req  = r_popReq;
   assign rf_we    = r_rfWe;
   assign rf_waddr = r_rfWaddr;
   assign rf_wdata = r_rfWdata;
   assign pc_load  = r_pcLoad;
   assign pc_value = r_pcValue;
   assign restored = r_restored;
   assign err      = r_err;

endmodule

// File: tb/tb_axa_undo_unwinder.sv
// Bench for axa_undo_unwinder: a queue-based undo stack drives the pop
// handshake and a reference walk of the same stack predicts each unwind.
module tb_axa_undo_unwinder;
   import axa_pkg::*;

   typedef struct {
      logic [1:0]  tag;
      logic [3:0]  regAddr;
      logic [15:0] data;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        stall;
   logic        pop_req;
   logic        pop_ack;
   logic [15:0] pop_data;
   logic [3:0]  pop_reg;
   logic [1:0]  pop_tag;
   logic        stack_empty;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        pc_load;
   logic [15:0] pc_value;
   logic [4:0]  restored;
   logic        err;

   axa_undo_unwinder dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .stall(stall),
      .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data),
      .pop_reg(pop_reg), .pop_tag(pop_tag), .stack_empty(stack_empty),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pc_load(pc_load), .pc_value(pc_value), .restored(restored), .err(err)
   );

   always #5 clk = ~clk;

   entry_t      stk[$];
   logic [19:0] obsWrites[$];
   logic [19:0] expWrites[$];
   int          fixedDelay = 0;
   bit          randomDelay = 0;
   int          ackWait = 0;
   int          ackTarget = 0;
   int          cycleCnt = 0;
   int          pcCount = 0;
   int          pcCycle = 0;
   int          busyCycles = 0;
   int          reqRises = 0;
   int          stallErrs = 0;
   int          startCycle = 0;
   logic [15:0] obsPc = '0;
   logic        prevReq = 1'b0;
   int          checks = 0;
   int          failures = 0;

   // Undo stack model: top of stack is the back of the queue; an entry is
   // removed on the falling edge after the rising edge that saw its ack.
   always @(negedge clk) begin
      if (pop_ack) begin
         void'(stk.pop_back());
         pop_ack   = 1'b0;
         ackWait   = 0;
         ackTarget = randomDelay ? int'($urandom_range(0, 3)) : fixedDelay;
      end
      if (!pop_ack && pop_req === 1'b1 && stk.size() > 0) begin
         if (ackWait >= ackTarget) begin
            pop_ack  = 1'b1;
            pop_tag  = stk[$].tag;
            pop_reg  = stk[$].regAddr;
            pop_data = stk[$].data;
         end else begin
            ackWait++;
         end
      end
      if (!pop_ack) begin
         pop_tag  = 2'b11;
         pop_reg  = 4'($urandom);
         pop_data = 16'($urandom);
      end
      stack_empty = (stk.size() == 0);
   end

   // Observation of the register-file, PC and handshake side, one step after each rising edge.
   always @(posedge clk) begin
      #1;
      cycleCnt++;
      if (rf_we) obsWrites.push_back({rf_waddr, rf_wdata});
      if (pc_load) begin
         pcCount++;
         obsPc   = pc_value;
         pcCycle = cycleCnt;
      end
      if (busy) busyCycles++;
      if (stall !== busy) stallErrs++;
      if (pop_req && !prevReq) reqRises++;
      prevReq = pop_req;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference unwind: walk the stack from the top, restoring registers until
   // a land marker, a reserved tag, underflow, or the sixteenth restore.
   task automatic modelUnwind(output int nWrites, output bit expErr, output bit pcValid,
                              output logic [15:0] expPc, output int consumed, output bit underflow);
      int idx;
      expWrites.delete();
      nWrites   = 0;
      expErr    = 0;
      pcValid   = 0;
      expPc     = '0;
      consumed  = 0;
      underflow = 0;
      idx       = stk.size() - 1;
      while (1'b1) begin
         if (idx < 0) begin
            expErr    = 1;
            underflow = 1;
            break;
         end
         consumed++;
         if (stk[idx].tag == TAG_REG) begin
            expWrites.push_back({stk[idx].regAddr, stk[idx].data});
            nWrites++;
            if (nWrites == AXA_MAX_UNWIND) begin
               expErr = 1;
               break;
            end
         end else if (stk[idx].tag == TAG_LAND) begin
            pcValid = 1;
            expPc   = stk[idx].data;
            break;
         end else begin
            expErr = 1;
            break;
         end
         idx--;
      end
   endtask

   task automatic pushEntry(input logic [1:0] tag, input logic [3:0] regAddr, input logic [15:0] data);
      entry_t e;
      e.tag     = tag;
      e.regAddr = regAddr;
      e.data    = data;
      stk.push_back(e);
   endtask

   task automatic clearObs();
      obsWrites.delete();
      pcCount    = 0;
      busyCycles = 0;
      reqRises   = 0;
      stallErrs  = 0;
   endtask

   task automatic pulseStart(input int delay, input bit rnd);
      fixedDelay  = delay;
      randomDelay = rnd;
      ackWait     = 0;
      ackTarget   = rnd ? int'($urandom_range(0, 3)) : delay;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #2;
      startCycle = cycleCnt;
   endtask

   task automatic applyStimulus(input string name, input int delay, input bit rnd, input bit extraStart);
      int          nWrites, consumed, startSize;
      bit          expErr, pcValid, underflow, done;
      logic [15:0] expPc;
      modelUnwind(nWrites, expErr, pcValid, expPc, consumed, underflow);
      startSize = stk.size();
      clearObs();
      pulseStart(delay, rnd);
      done = 0;
      for (int i = 1; i <= 600; i++) begin
         @(negedge clk);
         start = extraStart && (i == 2);
         if (!busy && i >= 3) begin
            done = 1;
            break;
         end
      end
      start = 1'b0;
      checkOutput({name, ":finished"}, 64'(done), 64'd1);
      checkOutput({name, ":nwrites"}, 64'(obsWrites.size()), 64'(expWrites.size()));
      for (int i = 0; i < expWrites.size() && i < obsWrites.size(); i++)
         checkOutput({name, ":write"}, 64'(obsWrites[i]), 64'(expWrites[i]));
      checkOutput({name, ":pcloads"}, 64'(pcCount), 64'(pcValid));
      if (pcValid) begin
         checkOutput({name, ":pc"}, 64'(obsPc), 64'(expPc));
         if (delay == 0 && !rnd)
            checkOutput({name, ":latency"}, 64'(pcCycle - startCycle + 1), 64'(2 * nWrites + 2));
      end
      checkOutput({name, ":err"}, 64'(err), 64'(expErr));
      checkOutput({name, ":restored"}, 64'(restored), 64'(nWrites));
      checkOutput({name, ":remaining"}, 64'(stk.size()), 64'(startSize - consumed));
      checkOutput({name, ":popreqs"}, 64'(reqRises), 64'(consumed + int'(underflow)));
      checkOutput({name, ":stall"}, 64'(stallErrs), 64'd0);
   endtask

   task automatic loadTest1Stack();
      stk.delete();
      pushEntry(TAG_LAND, 4'd0, 16'h0040);
      pushEntry(TAG_REG, 4'd3, 16'h1234);
      pushEntry(TAG_REG, 4'd5, 16'hBEEF);
   endtask

   initial begin
      bit          gotWrite;
      int          len, r;
      logic [1:0]  tag;
      reset       = 1'b0;
      start       = 1'b0;
      pop_ack     = 1'b0;
      pop_data    = '0;
      pop_reg     = '0;
      pop_tag     = 2'b11;
      stack_empty = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs",
                  64'({busy, stall, pop_req, rf_we, rf_waddr, rf_wdata, pc_load, pc_value, restored, err}), 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      loadTest1Stack();
      applyStimulus("t1_basic", 0, 0, 0);
      checkOutput("t1_restored_two", 64'(restored), 64'd2);

      stk.delete();
      pushEntry(TAG_LAND, 4'd0, 16'h0010);
      applyStimulus("t2_land_only", 0, 0, 0);
      checkOutput("t2_busy_cycles", 64'(busyCycles), 64'd2);

      stk.delete();
      pushEntry(TAG_REG, 4'd1, 16'h0001);
      applyStimulus("t3_underflow", 0, 0, 0);

      loadTest1Stack();
      applyStimulus("t4_slow_ack_restart", 3, 0, 1);

      stk.delete();
      for (int i = 0; i < 17; i++) pushEntry(TAG_REG, 4'($urandom), 16'($urandom));
      applyStimulus("t5_overflow", 0, 0, 0);
      checkOutput("t5_left_one", 64'(stk.size()), 64'd1);

      // Abandon an unwind while the first restore is being written.
      loadTest1Stack();
      clearObs();
      pulseStart(0, 0);
      gotWrite = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (rf_we) begin
            gotWrite = 1;
            break;
         end
      end
      checkOutput("t6_reached_write", 64'(gotWrite), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("t6_reset_outputs",
                  64'({busy, stall, pop_req, rf_we, rf_waddr, rf_wdata, pc_load, pc_value, restored, err}), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("t6_idle_after_reset", 64'({busy, pop_req}), 64'd0);
      applyStimulus("t6_resume", 0, 0, 0);
      checkOutput("t6_resume_pc", 64'(obsPc), 64'h0040);

      for (int run = 0; run < 40; run++) begin
         stk.delete();
         len = $urandom_range(0, 20);
         for (int i = 0; i < len; i++) begin
            r   = $urandom_range(0, 11);
            tag = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r <= 3) ? TAG_LAND : TAG_REG;
            pushEntry(tag, 4'($urandom), 16'($urandom));
         end
         applyStimulus("rand", (run % 2 == 0) ? 0 : 1, run % 3 == 0, run % 4 == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
